mem_if_arbiter: RTL and testbench



---
 rtl/vcpu32_pkg.sv | 30 +++
 rtl/mem_if_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_if_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vcpu32_pkg.sv
// ---------------------------------------------------------------------------
// vcpu32_pkg
// Shared types and helpers for the vcpu32 memory subsystem.
//   arb_state_t    : memory-interface arbiter FSM states
//   arb_owner_t    : which cache currently owns the memory port
//   DEF_LINE_WORDS : default number of words per cache line
//   beat_idx_width : width of a word-within-line index
// ---------------------------------------------------------------------------
package vcpu32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        XFER,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int DEF_LINE_WORDS = 4;

    // Never returns 0, so a beat index is always at least one bit wide.
    function automatic int beat_idx_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/mem_if_arbiter.sv
// ---------------------------------------------------------------------------
// mem_if_arbiter
// Shares one line-burst memory port between the L1 I-cache (line fills) and
// the L1 D-cache (line fills and write-backs). The I-cache has strict
// priority; a granted transfer always runs to completion.
//
// Ports
//   clk, rst                       : clock, asynchronous active-low reset
//   i_req, i_adr                   : I-cache fill request / miss address
//   i_rvalid, i_done               : I-cache read beat valid / completion pulse
//   d_req, d_we, d_adr, d_wdata    : D-cache request, direction, address,
//                                    write word at index beat_idx
//   d_rvalid, d_wnext, d_done      : D-cache read beat valid / write beat
//                                    taken / completion pulse
//   rdata, beat_idx, busy          : shared read data, current word index,
//                                    arbiter not idle
//   mem_req, mem_we, mem_adr       : memory request, direction, line address
//   mem_ack                        : memory accepted the request
//   mem_wdata, mem_wready          : write beat data / memory takes beat
//   mem_rdata, mem_rvalid          : read beat data / read beat valid
// ---------------------------------------------------------------------------
module mem_if_arbiter
    import vcpu32_pkg::*;
#(
    parameter  int WORD_LENGTH = 32,
    parameter  int ADR_WIDTH   = 32,
    parameter  int LINE_WORDS  = DEF_LINE_WORDS,
    localparam int IDX_W       = beat_idx_width(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_req,
    input  logic [ADR_WIDTH-1:0]   i_adr,
    output logic                   i_rvalid,
    output logic                   i_done,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADR_WIDTH-1:0]   d_adr,
    input  logic [WORD_LENGTH-1:0] d_wdata,
    output logic                   d_rvalid,
    output logic                   d_wnext,
    output logic                   d_done,

    output logic [WORD_LENGTH-1:0] rdata,
    output logic [IDX_W-1:0]       beat_idx,
    output logic                   busy,

    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADR_WIDTH-1:0]   mem_adr,
    input  logic                   mem_ack,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_wready,
    input  logic [WORD_LENGTH-1:0] mem_rdata,
    input  logic                   mem_rvalid
);

    // Byte-offset bits inside one line; these are forced to zero on grant.
    localparam int                   OFF_W     = $clog2(LINE_WORDS * WORD_LENGTH / 8);
    localparam logic [ADR_WIDTH-1:0] LINE_MASK = {ADR_WIDTH{1'b1}} << OFF_W;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    logic [ADR_WIDTH-1:0] adr_q,   adr_d;
    logic                 we_q,    we_d;
    logic [IDX_W-1:0]     cnt_q,   cnt_d;

    logic in_xfer;
    logic beat;

    assign in_xfer = (state_q == XFER);
    // A beat is a handshake in the direction of the current transfer only;
    // strobes for the other direction are ignored.
    assign beat    = in_xfer && (we_q ? mem_wready : mem_rvalid);

    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        adr_d   = adr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    owner_d = OWN_I;
                    adr_d   = i_adr & LINE_MASK;
                    we_d    = 1'b0;
                    state_d = ADDR;
                end else if (d_req) begin
                    owner_d = OWN_D;
                    adr_d   = d_adr & LINE_MASK;
                    we_d    = d_we;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Requests are not sampled here, which guarantees one IDLE
                // cycle for the requester to drop its req after done.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            adr_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign beat_idx  = cnt_q;

    assign mem_req   = (state_q == ADDR);
    assign mem_we    = we_q && busy;
    assign mem_adr   = adr_q;

    // Data paths are combinational pass-throughs, gated to zero when not in
    // a transfer of the matching direction.
    assign rdata     = (in_xfer && !we_q) ? mem_rdata : '0;
    assign mem_wdata = (in_xfer &&  we_q) ? d_wdata   : '0;

    assign i_rvalid  = in_xfer && !we_q && (owner_q == OWN_I) && mem_rvalid;
    assign d_rvalid  = in_xfer && !we_q && (owner_q == OWN_D) && mem_rvalid;
    // Only the D-cache ever latches we=1, so no owner check is needed.
    assign d_wnext   = in_xfer &&  we_q && mem_wready;

    assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_if_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_if_arbiter
// Directed, self-checking bench for mem_if_arbiter (LINE_WORDS = 4, 32-bit
// words, so line addresses have their low 4 bits cleared). Inputs change
// 2 ns after a rising edge; outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_if_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_adr;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic        d_wnext;
    logic        d_done;
    logic [31:0] rdata;
    logic [1:0]  beat_idx;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic        mem_ack;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int errors = 0;
    int checks = 0;

    mem_if_arbiter #(
        .WORD_LENGTH(32),
        .ADR_WIDTH  (32),
        .LINE_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_adr     (i_adr),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_adr     (d_adr),
        .d_wdata   (d_wdata),
        .d_rvalid  (d_rvalid),
        .d_wnext   (d_wnext),
        .d_done    (d_done),
        .rdata     (rdata),
        .beat_idx  (beat_idx),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_ack   (mem_ack),
        .mem_wdata (mem_wdata),
        .mem_wready(mem_wready),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Grant sequence used by several scenarios: the request must already be
    // driven; this walks IDLE -> ADDR -> XFER with an immediate ack.
    task automatic grant_and_ack();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req = 0; i_adr = '0; d_req = 0; d_we = 0; d_adr = '0; d_wdata = '0;
        mem_ack = 0; mem_wready = 0; mem_rdata = '0; mem_rvalid = 0;
        #3;
        checks++;
        if ({mem_req, mem_we, mem_adr, busy, i_done, d_done, i_rvalid, d_rvalid,
             d_wnext, beat_idx} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b adr=%h busy=%b idx=%0d expected all 0",
                     mem_req, mem_we, mem_adr, busy, beat_idx);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_i_fill();
        i_req = 1'b1;
        i_adr = 32'h0000_1234;
        #1;
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL fill_idle: got busy/req=%b expected 00", {busy, mem_req});
        end
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr, busy} !== {1'b1, 1'b0, 32'h0000_1230, 1'b1}) begin
            errors++;
            $display("FAIL fill_addr: got req=%b we=%b adr=%h expected req=1 we=0 adr=00001230",
                     mem_req, mem_we, mem_adr);
        end
        // Memory withholds ack for two more cycles, acking on the third.
        for (int w = 0; w < 2; w++) begin
            tick();
            #1;
            checks++;
            if ({mem_req, mem_adr} !== {1'b1, 32'h0000_1230}) begin
                errors++;
                $display("FAIL fill_wait_ack%0d: got req=%b adr=%h expected req=1 adr=00001230",
                         w, mem_req, mem_adr);
            end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, beat_idx} !== 3'b000) begin
            errors++;
            $display("FAIL fill_xfer_entry: got req=%b idx=%0d expected req=0 idx=0", mem_req, beat_idx);
        end
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA0 + 32'(k);
            #1;
            checks++;
            if ({i_rvalid, d_rvalid, beat_idx, rdata} !== {1'b1, 1'b0, 2'(k), 32'hA0 + 32'(k)}) begin
                errors++;
                $display("FAIL fill_beat%0d: got i_rv=%b d_rv=%b idx=%0d rdata=%h expected 1 0 %0d %h",
                         k, i_rvalid, d_rvalid, beat_idx, rdata, k, 32'hA0 + 32'(k));
            end
            tick();
            mem_rvalid = 1'b0;
            if (k < 3) begin
                #1;
                checks++;
                if ({i_rvalid, i_done, beat_idx} !== {1'b0, 1'b0, 2'(k + 1)}) begin
                    errors++;
                    $display("FAIL fill_gap%0d: got i_rv=%b i_done=%b idx=%0d expected 0 0 %0d",
                             k, i_rvalid, i_done, beat_idx, k + 1);
                end
                tick();
            end
        end
        #1;
        checks++;
        if ({i_done, d_done, busy, beat_idx} !== 5'b10100) begin
            errors++;
            $display("FAIL fill_done: got i_done=%b d_done=%b busy=%b idx=%0d expected 1 0 1 0",
                     i_done, d_done, busy, beat_idx);
        end
        i_req = 1'b0;
        tick();
        #1;
        checks++;
        if ({i_done, busy, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL fill_after_done: got i_done=%b busy=%b req=%b expected 000", i_done, busy, mem_req);
        end
    endtask

    task automatic test_simultaneous();
        i_req = 1'b1; i_adr = 32'h2000_0004;
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h3010_001C;
        tick();
        #1;
        checks++;
        if ({mem_adr, mem_we} !== {32'h2000_0000, 1'b0}) begin
            errors++;
            $display("FAIL simul_grant_i: got adr=%h we=%b expected 20000000 0", mem_adr, mem_we);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB0 + 32'(k);
            #1;
            checks++;
            if ({i_rvalid, d_rvalid} !== 2'b10) begin
                errors++;
                $display("FAIL simul_i_beat%0d: got i_rv=%b d_rv=%b expected 1 0", k, i_rvalid, d_rvalid);
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({i_done, d_done} !== 2'b10) begin
            errors++;
            $display("FAIL simul_i_done: got i_done=%b d_done=%b expected 1 0", i_done, d_done);
        end
        i_req = 1'b0;
        tick();
        #1;
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL simul_idle_gap: got req=%b busy=%b expected 0 0", mem_req, busy);
        end
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b0, 32'h3010_0010}) begin
            errors++;
            $display("FAIL simul_grant_d: got req=%b we=%b adr=%h expected 1 0 30100010",
                     mem_req, mem_we, mem_adr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hC0 + 32'(k);
            #1;
            checks++;
            if ({i_rvalid, d_rvalid, beat_idx, rdata} !== {1'b0, 1'b1, 2'(k), 32'hC0 + 32'(k)}) begin
                errors++;
                $display("FAIL simul_d_beat%0d: got i_rv=%b d_rv=%b idx=%0d rdata=%h expected 0 1 %0d %h",
                         k, i_rvalid, d_rvalid, beat_idx, rdata, k, 32'hC0 + 32'(k));
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({i_done, d_done} !== 2'b01) begin
            errors++;
            $display("FAIL simul_d_done: got i_done=%b d_done=%b expected 0 1", i_done, d_done);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_write_back();
        int pat [5] = '{1, 0, 1, 1, 1};
        int exp_idx;
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h8000_0040;
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b1, 32'h8000_0040}) begin
            errors++;
            $display("FAIL wb_addr: got req=%b we=%b adr=%h expected 1 1 80000040", mem_req, mem_we, mem_adr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_idx = 0;
        for (int j = 0; j < 5; j++) begin
            mem_wready = 1'(pat[j]);
            d_wdata    = 32'hD000_0000 + 32'(exp_idx);
            #1;
            checks++;
            if ({d_wnext, beat_idx, mem_wdata} !== {1'(pat[j]), 2'(exp_idx), 32'hD000_0000 + 32'(exp_idx)}) begin
                errors++;
                $display("FAIL wb_cycle%0d: got wnext=%b idx=%0d wdata=%h expected %0d %0d %h",
                         j, d_wnext, beat_idx, mem_wdata, pat[j], exp_idx, 32'hD000_0000 + 32'(exp_idx));
            end
            tick();
            if (pat[j] != 0) exp_idx++;
        end
        mem_wready = 1'b0;
        #1;
        checks++;
        if ({d_done, i_done, busy} !== 3'b101) begin
            errors++;
            $display("FAIL wb_done: got d_done=%b i_done=%b busy=%b expected 1 0 1", d_done, i_done, busy);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        #1;
        checks++;
        if ({busy, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL wb_idle: got busy=%b we=%b expected 0 0", busy, mem_we);
        end
    endtask

    task automatic test_no_preempt();
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h8000_0100;
        grant_and_ack();
        // I-cache miss and a stray read strobe arrive mid write-back.
        i_req = 1'b1; i_adr = 32'h0000_5000;
        mem_rvalid = 1'b1; mem_wready = 1'b0;
        #1;
        checks++;
        if ({i_rvalid, d_rvalid, d_wnext, mem_req} !== 4'b0000) begin
            errors++;
            $display("FAIL nop_stray: got i_rv=%b d_rv=%b wnext=%b req=%b expected 0000",
                     i_rvalid, d_rvalid, d_wnext, mem_req);
        end
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({beat_idx, busy, mem_adr} !== {2'd0, 1'b1, 32'h8000_0100}) begin
            errors++;
            $display("FAIL nop_hold: got idx=%0d busy=%b adr=%h expected 0 1 80000100", beat_idx, busy, mem_adr);
        end
        for (int k = 0; k < 4; k++) begin
            mem_wready = 1'b1;
            tick();
        end
        mem_wready = 1'b0;
        #1;
        checks++;
        if ({d_done, i_done} !== 2'b10) begin
            errors++;
            $display("FAIL nop_d_done: got d_done=%b i_done=%b expected 1 0", d_done, i_done);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr} !== {1'b1, 1'b0, 32'h0000_5000}) begin
            errors++;
            $display("FAIL nop_i_grant: got req=%b we=%b adr=%h expected 1 0 00005000", mem_req, mem_we, mem_adr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (i_done !== 1'b1) begin
            errors++;
            $display("FAIL nop_i_done: got %b expected 1", i_done);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_adr = 32'h1000_0008;
        grant_and_ack();
        mem_rvalid = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({beat_idx, i_rvalid, mem_adr} !== {2'd2, 1'b1, 32'h1000_0000}) begin
            errors++;
            $display("FAIL rmid_before: got idx=%0d i_rv=%b adr=%h expected 2 1 10000000", beat_idx, i_rvalid, mem_adr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr, busy, i_done, d_done, i_rvalid, d_rvalid,
             d_wnext, beat_idx} !== 42'd0) begin
            errors++;
            $display("FAIL rmid_outputs: got req=%b adr=%h busy=%b i_rv=%b idx=%0d expected all 0",
                     mem_req, mem_adr, busy, i_rvalid, beat_idx);
        end
        i_req = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if ({i_done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_no_done: got i_done=%b busy=%b expected 0 0", i_done, busy);
        end
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h4000_0020;
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_adr, beat_idx} !== {1'b1, 1'b0, 32'h4000_0020, 2'd0}) begin
            errors++;
            $display("FAIL rmid_new_grant: got req=%b we=%b adr=%h idx=%0d expected 1 0 40000020 0",
                     mem_req, mem_we, mem_adr, beat_idx);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            #1;
            checks++;
            if ({d_rvalid, i_rvalid, beat_idx} !== {1'b1, 1'b0, 2'(k)}) begin
                errors++;
                $display("FAIL rmid_d_beat%0d: got d_rv=%b i_rv=%b idx=%0d expected 1 0 %0d",
                         k, d_rvalid, i_rvalid, beat_idx, k);
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({d_done, i_done} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_d_done: got d_done=%b i_done=%b expected 1 0", d_done, i_done);
        end
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_simultaneous();
        test_write_back();
        test_no_preempt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
